// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. The ALU and LS units each push completed results
// into a private FIFO. One FIFO head per cycle is picked round-robin and
// registered onto the broadcast bus. A mispredict flushes everything buffered.

// One FU result FIFO. Pushes are gated by ready, and both ops are gated by flush.
module cdb_fifo #(
  parameter int W      = 8,
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         ready,
  output logic         nonempty
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [W-1:0]  mem [QDEPTH];
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  // A push while full is dropped. The pop is only honoured when the FIFO holds data.
  assign ready    = (count < FULL);
  assign nonempty = (count != '0);
  assign do_push  = push & ready & ~flush;
  assign do_pop   = pop & nonempty & ~flush;
  assign head     = mem[rd_ptr];

  // Occupancy and pointers. The pointers are log2(QDEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage. It is not reset, because a reset empty FIFO never exposes stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module cdb_arbiter #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int QDEPTH       = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rob_is_mispred,
  input  logic                    in_alu_valid,
  input  logic [GPR_SIZE-1:0]     in_alu_value,
  input  logic [ROB_IDX_SIZE-1:0] in_alu_rob_index,
  input  logic                    in_alu_set_nzcv,
  input  logic [3:0]              in_alu_nzcv,
  output logic                    out_alu_ready,
  input  logic                    in_ls_valid,
  input  logic [GPR_SIZE-1:0]     in_ls_value,
  input  logic [ROB_IDX_SIZE-1:0] in_ls_rob_index,
  input  logic                    in_ls_set_nzcv,
  input  logic [3:0]              in_ls_nzcv,
  output logic                    out_ls_ready,
  output logic                    out_cdb_done,
  output logic [ROB_IDX_SIZE-1:0] out_cdb_index,
  output logic [GPR_SIZE-1:0]     out_cdb_value,
  output logic                    out_cdb_set_nzcv,
  output logic [3:0]              out_cdb_nzcv,
  output logic                    out_cdb_src
);
  localparam int NUM_FU = 2;  // lane 0 = ALU, lane 1 = LS

  typedef struct packed {
    logic                    set_nzcv;
    logic [3:0]              nzcv;
    logic [ROB_IDX_SIZE-1:0] idx;
    logic [GPR_SIZE-1:0]     value;
  } rec_t;

  rec_t [NUM_FU-1:0] rec_in, head;
  logic [NUM_FU-1:0] push, pop, ready, nonempty;
  logic              gnt, sel, last_grant;

  assign rec_in[0] = '{in_alu_set_nzcv, in_alu_nzcv, in_alu_rob_index, in_alu_value};
  assign rec_in[1] = '{in_ls_set_nzcv, in_ls_nzcv, in_ls_rob_index, in_ls_value};
  assign push      = {in_ls_valid, in_alu_valid};
  assign out_alu_ready = ready[0];
  assign out_ls_ready  = ready[1];

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    cdb_fifo #(.W($bits(rec_t)), .QDEPTH(QDEPTH)) u_fifo (
      .clk      (in_clk),
      .rst      (in_rst),
      .flush    (in_rob_is_mispred),
      .push     (push[g]),
      .din      (rec_in[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .ready    (ready[g]),
      .nonempty (nonempty[g])
    );
  end

  // Round-robin pick. On a tie the FU that did not win last goes next.
  always_comb begin
    gnt = 1'b0;
    sel = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      gnt = 1'b1;
      sel = ~last_grant;
    end else if (nonempty[0]) begin
      gnt = 1'b1;
      sel = 1'b0;
    end else if (nonempty[1]) begin
      gnt = 1'b1;
      sel = 1'b1;
    end
  end

  assign pop = gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // Registered broadcast. Data holds when idle, and a flush kills done but keeps the grant history.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_cdb_done     <= 1'b0;
      out_cdb_index    <= '0;
      out_cdb_value    <= '0;
      out_cdb_set_nzcv <= 1'b0;
      out_cdb_nzcv     <= '0;
      out_cdb_src      <= 1'b0;
      last_grant       <= 1'b1;
    end else if (in_rob_is_mispred) begin
      out_cdb_done <= 1'b0;
    end else if (gnt) begin
      out_cdb_done     <= 1'b1;
      out_cdb_index    <= head[sel].idx;
      out_cdb_value    <= head[sel].value;
      out_cdb_set_nzcv <= head[sel].set_nzcv;
      out_cdb_nzcv     <= head[sel].nzcv;
      out_cdb_src      <= sel;
      last_grant       <= sel;
    end else begin
      out_cdb_done <= 1'b0;
    end
  end
endmodule
